// File: rtl/rv32i_pkg.sv
// RV32I encodings and ALU operation codes shared by the execute stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // ALU func3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch func3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store func3 (size in [1:0], unsigned in [2])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // OP-IMM has no SUBI, so func7[5] only matters for its shifts.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_op);
        case (f3)
            F3_ADD:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return f7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// EX/MEM pipeline register bus: ex_stage drives it, the MEM stage consumes it.
interface ex_stage_if;
    import rv32i_pkg::*;

    logic        mem_valid;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_func3;
    logic        mem_is_load;
    logic        mem_is_store;
    logic        mem_reg_write;

    modport master (output mem_valid, mem_alu_result, mem_store_data, mem_rd_addr,
                           mem_func3, mem_is_load, mem_is_store, mem_reg_write);
    modport slave  (input  mem_valid, mem_alu_result, mem_store_data, mem_rd_addr,
                           mem_func3, mem_is_load, mem_is_store, mem_reg_write);
endinterface

// File: rtl/rv32i_alu.sv
// Purely combinational RV32I integer ALU.
module rv32i_alu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  alu_op_e         alu_op,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;
    assign shamt = operand_b[4:0];

    // Select the operation; all arithmetic wraps at XLEN bits.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_SLL:  result = operand_a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_SRL:  result = operand_a >> shamt;
            ALU_SRA:  result = $signed(operand_a) >>> shamt;
            ALU_OR:   result = operand_a | operand_b;
            ALU_AND:  result = operand_a & operand_b;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, load-use hazard, branch/jump resolution, EX/MEM register.
module ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_func3,
    input  logic [6:0]      ex_func7,
    input  logic [4:0]      ex_rs1_addr,
    input  logic [4:0]      ex_rs2_addr,
    input  logic [4:0]      ex_rd_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    ex_stage_if.master      mem
);
    logic is_op, is_opi, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
    logic supported, rs1_used, rs2_used, writes_rd, go, taken;
    logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_res, target;
    alu_op_e alu_op;

    logic            mem_valid_q,      mem_valid_d;
    logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d;
    logic [XLEN-1:0] mem_store_data_q, mem_store_data_d;
    logic [4:0]      mem_rd_addr_q,    mem_rd_addr_d;
    logic [2:0]      mem_func3_q,      mem_func3_d;
    logic            mem_is_load_q,    mem_is_load_d;
    logic            mem_is_store_q,   mem_is_store_d;
    logic            mem_reg_write_q,  mem_reg_write_d;

    logic unused_func7;
    assign unused_func7 = ^{ex_func7[6], ex_func7[4:0]};

    assign is_op    = ex_opcode == OPC_OP;
    assign is_opi   = ex_opcode == OPC_OP_IMM;
    assign is_lui   = ex_opcode == OPC_LUI;
    assign is_auipc = ex_opcode == OPC_AUIPC;
    assign is_jal   = ex_opcode == OPC_JAL;
    assign is_jalr  = ex_opcode == OPC_JALR;
    assign is_br    = ex_opcode == OPC_BRANCH;
    assign is_ld    = ex_opcode == OPC_LOAD;
    assign is_st    = ex_opcode == OPC_STORE;

    assign supported = is_op | is_opi | is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st;
    assign rs1_used  = supported & ~(is_lui | is_auipc | is_jal);
    assign rs2_used  = is_op | is_br | is_st;
    assign writes_rd = is_op | is_opi | is_lui | is_auipc | is_jal | is_jalr | is_ld;

    // Operand bypass: a load result in MEM is not ready yet, that case is the stall below.
    always_comb begin
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
        if (ex_rs1_addr == 5'd0)
            rs1_val = '0;
        else if (FWD_EN && mem_valid_q && mem_reg_write_q && !mem_is_load_q && mem_rd_addr_q == ex_rs1_addr)
            rs1_val = mem_alu_result_q;
        else if (FWD_EN && wb_reg_write && wb_rd_addr == ex_rs1_addr)
            rs1_val = wb_data;
        if (ex_rs2_addr == 5'd0)
            rs2_val = '0;
        else if (FWD_EN && mem_valid_q && mem_reg_write_q && !mem_is_load_q && mem_rd_addr_q == ex_rs2_addr)
            rs2_val = mem_alu_result_q;
        else if (FWD_EN && wb_reg_write && wb_rd_addr == ex_rs2_addr)
            rs2_val = wb_data;
    end

    assign stall = ex_valid & mem_valid_q & mem_is_load_q & (mem_rd_addr_q != 5'd0) &
                   ((rs1_used & (mem_rd_addr_q == ex_rs1_addr)) |
                    (rs2_used & (mem_rd_addr_q == ex_rs2_addr)));
    assign go = ex_valid & supported & ~stall;

    // Pick ALU operands and operation per opcode; address/link math reuses the adder.
    always_comb begin
        op_a   = rs1_val;
        op_b   = ex_imm;
        alu_op = ALU_ADD;
        if (is_op) begin
            op_b   = rs2_val;
            alu_op = alu_decode(ex_func3, ex_func7[5], 1'b1);
        end else if (is_opi) begin
            alu_op = alu_decode(ex_func3, ex_func7[5], 1'b0);
        end else if (is_lui) begin
            op_a = '0;
        end else if (is_auipc) begin
            op_a = ex_pc;
        end else if (is_jal || is_jalr) begin
            op_a = ex_pc;
            op_b = XLEN'(4);
        end
    end

    rv32i_alu #(.XLEN(XLEN)) u_alu (
        .operand_a (op_a),
        .operand_b (op_b),
        .alu_op    (alu_op),
        .result    (alu_res)
    );

    // Branch condition and jump target.
    always_comb begin
        taken = 1'b0;
        case (ex_func3)
            F3_BEQ:  taken = rs1_val == rs2_val;
            F3_BNE:  taken = rs1_val != rs2_val;
            F3_BLT:  taken = $signed(rs1_val) <  $signed(rs2_val);
            F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: taken = rs1_val <  rs2_val;
            F3_BGEU: taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
        target = is_jalr ? ((rs1_val + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);
    end

    assign flush       = ex_valid & ~stall & (is_jal | is_jalr | (is_br & taken));
    assign redirect_pc = flush ? target : '0;

    // Next EX/MEM contents: the executed instruction, or an all-zero bubble.
    always_comb begin
        mem_valid_d      = go;
        mem_alu_result_d = '0;
        mem_store_data_d = '0;
        mem_rd_addr_d    = '0;
        mem_func3_d      = '0;
        mem_is_load_d    = 1'b0;
        mem_is_store_d   = 1'b0;
        mem_reg_write_d  = 1'b0;
        if (go) begin
            mem_alu_result_d = is_br ? '0 : alu_res;
            mem_store_data_d = rs2_val;
            mem_rd_addr_d    = ex_rd_addr;
            mem_func3_d      = ex_func3;
            mem_is_load_d    = is_ld;
            mem_is_store_d   = is_st;
            mem_reg_write_d  = writes_rd & (ex_rd_addr != 5'd0);
        end
    end

    // EX/MEM register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_rd_addr_q    <= '0;
            mem_func3_q      <= '0;
            mem_is_load_q    <= 1'b0;
            mem_is_store_q   <= 1'b0;
            mem_reg_write_q  <= 1'b0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_store_data_q <= mem_store_data_d;
            mem_rd_addr_q    <= mem_rd_addr_d;
            mem_func3_q      <= mem_func3_d;
            mem_is_load_q    <= mem_is_load_d;
            mem_is_store_q   <= mem_is_store_d;
            mem_reg_write_q  <= mem_reg_write_d;
        end
    end

    assign mem.mem_valid      = mem_valid_q;
    assign mem.mem_alu_result = mem_alu_result_q;
    assign mem.mem_store_data = mem_store_data_q;
    assign mem.mem_rd_addr    = mem_rd_addr_q;
    assign mem.mem_func3      = mem_func3_q;
    assign mem.mem_is_load    = mem_is_load_q;
    assign mem.mem_is_store   = mem_is_store_q;
    assign mem.mem_reg_write  = mem_reg_write_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, load-use stall, branches, jumps, ALU corners, reset.
module tb_ex_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [6:0]  ex_opcode, ex_func7;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        stall, flush;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    ex_stage_if mif ();

    ex_stage #(.XLEN(32), .FWD_EN(1)) dut (
        .clk(clk), .rst_(rst_), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .mem(mif.master)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        ex_valid = 1'b1; ex_opcode = opc; ex_func3 = f3; ex_func7 = f7;
        ex_rs1_addr = rs1; ex_rs2_addr = rs2; ex_rd_addr = rd;
        ex_imm = imm; ex_pc = pc; rf_rs1_data = d1; rf_rs2_data = d2;
        #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_func3 = '0; ex_func7 = '0;
        ex_rs1_addr = '0; ex_rs2_addr = '0; ex_rd_addr = '0; ex_imm = '0; ex_pc = '0;
        rf_rs1_data = '0; rf_rs2_data = '0; wb_reg_write = 1'b0; wb_rd_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mif.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", mif.mem_valid); end
        total++; if (mif.mem_alu_result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", mif.mem_alu_result); end
        total++; if ({stall, flush, redirect_pc} !== 34'h0) begin bad++; $display("FAIL rst_ctrl got=%b/%b/%h exp=0", stall, flush, redirect_pc); end
        rst_ = 1'b1;
    endtask

    task automatic test_forward();
        drive(OPC_OP_IMM, F3_ADD, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0, 32'hDEAD, 32'h0);
        step();
        total++; if (mif.mem_alu_result !== 32'd5 || mif.mem_reg_write !== 1'b1) begin bad++; $display("FAIL addi got=%h/%b exp=5/1", mif.mem_alu_result, mif.mem_reg_write); end
        drive(OPC_OP, F3_ADD, 7'h0, 5'd1, 5'd1, 5'd2, 32'h0, 32'h4, 32'hDEAD, 32'hBEEF);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%b exp=0", stall); end
        step();
        total++; if (mif.mem_alu_result !== 32'd10 || mif.mem_rd_addr !== 5'd2) begin bad++; $display("FAIL fwd_add got=%h rd=%0d exp=a rd=2", mif.mem_alu_result, mif.mem_rd_addr); end
    endtask

    task automatic test_load_use();
        drive(OPC_LOAD, F3_LW, 7'h0, 5'd0, 5'd0, 5'd3, 32'h100, 32'h8, 32'h0, 32'h0);
        step();
        total++; if (mif.mem_is_load !== 1'b1 || mif.mem_alu_result !== 32'h100) begin bad++; $display("FAIL lw got=%b/%h exp=1/100", mif.mem_is_load, mif.mem_alu_result); end
        drive(OPC_OP, F3_ADD, 7'h0, 5'd3, 5'd0, 5'd4, 32'h0, 32'hC, 32'h5555, 32'h0);
        total++; if (stall !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b/%b exp=1/0", stall, flush); end
        step();
        total++; if (mif.mem_valid !== 1'b0 || mif.mem_alu_result !== 32'h0 || mif.mem_rd_addr !== 5'd0) begin bad++; $display("FAIL lu_bubble got=%b/%h/%0d exp=0/0/0", mif.mem_valid, mif.mem_alu_result, mif.mem_rd_addr); end
        wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'h1234; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall); end
        step();
        total++; if (mif.mem_valid !== 1'b1 || mif.mem_alu_result !== 32'h1234) begin bad++; $display("FAIL lu_wb got=%b/%h exp=1/1234", mif.mem_valid, mif.mem_alu_result); end
        wb_reg_write = 1'b0;
    endtask

    task automatic test_branch();
        drive(OPC_BRANCH, F3_BEQ, 7'h0, 5'd0, 5'd0, 5'd0, 32'd16, 32'h40, 32'h0, 32'h0);
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h50) begin bad++; $display("FAIL beq got=%b/%h exp=1/50", flush, redirect_pc); end
        step();
        total++; if (mif.mem_valid !== 1'b1 || mif.mem_reg_write !== 1'b0) begin bad++; $display("FAIL beq_mem got=%b/%b exp=1/0", mif.mem_valid, mif.mem_reg_write); end
        drive(OPC_BRANCH, F3_BNE, 7'h0, 5'd0, 5'd0, 5'd0, 32'd16, 32'h40, 32'h0, 32'h0);
        total++; if (flush !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL bne got=%b/%h exp=0/0", flush, redirect_pc); end
        // BLT -1 < 1 through register file data
        drive(OPC_BRANCH, F3_BLT, 7'h0, 5'd9, 5'd10, 5'd0, 32'hFFFFFFF0, 32'h100, 32'hFFFFFFFF, 32'h1);
        total++; if (flush !== 1'b1 || redirect_pc !== 32'hF0) begin bad++; $display("FAIL blt got=%b/%h exp=1/f0", flush, redirect_pc); end
        step();
        // stall beats flush: branch on a register still being loaded
        drive(OPC_LOAD, F3_LW, 7'h0, 5'd0, 5'd0, 5'd6, 32'h200, 32'h60, 32'h0, 32'h0);
        step();
        drive(OPC_BRANCH, F3_BEQ, 7'h0, 5'd6, 5'd0, 5'd0, 32'd8, 32'h64, 32'h77, 32'h0);
        total++; if (stall !== 1'b1 || flush !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL stall_prio got=%b/%b/%h exp=1/0/0", stall, flush, redirect_pc); end
        step();
        wb_reg_write = 1'b1; wb_rd_addr = 5'd6; wb_data = 32'h0; #1;
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h6C) begin bad++; $display("FAIL stall_resolve got=%b/%h exp=1/6c", flush, redirect_pc); end
        step();
        wb_reg_write = 1'b0;
    endtask

    task automatic test_jalr();
        drive(OPC_JALR, 3'b000, 7'h0, 5'd5, 5'd0, 5'd1, 32'd3, 32'h80, 32'h200, 32'h0);
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h202) begin bad++; $display("FAIL jalr_tgt got=%b/%h exp=1/202", flush, redirect_pc); end
        step();
        total++; if (mif.mem_alu_result !== 32'h84 || mif.mem_reg_write !== 1'b1 || mif.mem_rd_addr !== 5'd1) begin bad++; $display("FAIL jalr_link got=%h/%b/%0d exp=84/1/1", mif.mem_alu_result, mif.mem_reg_write, mif.mem_rd_addr); end
        drive(OPC_JAL, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'h90, 32'h0, 32'h0);
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h88) begin bad++; $display("FAIL jal got=%b/%h exp=1/88", flush, redirect_pc); end
        step();
        total++; if (mif.mem_reg_write !== 1'b0 || mif.mem_valid !== 1'b1) begin bad++; $display("FAIL jal_x0 got=%b/%b exp=0/1", mif.mem_reg_write, mif.mem_valid); end
    endtask

    task automatic test_alu();
        drive(OPC_OP_IMM, F3_SR, 7'h20, 5'd7, 5'd0, 5'd8, 32'h404, 32'h0, 32'h80000000, 32'h0);
        step();
        total++; if (mif.mem_alu_result !== 32'hF8000000) begin bad++; $display("FAIL srai got=%h exp=f8000000", mif.mem_alu_result); end
        drive(OPC_OP, F3_SLTU, 7'h0, 5'd9, 5'd10, 5'd11, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1);
        step();
        total++; if (mif.mem_alu_result !== 32'h0) begin bad++; $display("FAIL sltu got=%h exp=0", mif.mem_alu_result); end
        drive(OPC_OP, F3_SLT, 7'h0, 5'd9, 5'd10, 5'd12, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1);
        step();
        total++; if (mif.mem_alu_result !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=1", mif.mem_alu_result); end
        drive(OPC_OP, F3_ADD, 7'h0, 5'd9, 5'd10, 5'd13, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1);
        step();
        total++; if (mif.mem_alu_result !== 32'h0) begin bad++; $display("FAIL add_wrap got=%h exp=0", mif.mem_alu_result); end
        drive(OPC_OP, F3_ADD, 7'h20, 5'd9, 5'd10, 5'd14, 32'h0, 32'h0, 32'h5, 32'h7);
        step();
        total++; if (mif.mem_alu_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub got=%h exp=fffffffe", mif.mem_alu_result); end
        drive(OPC_LUI, 3'b000, 7'h0, 5'd31, 5'd0, 5'd15, 32'hABCDE000, 32'h0, 32'h1, 32'h0);
        step();
        total++; if (mif.mem_alu_result !== 32'hABCDE000) begin bad++; $display("FAIL lui got=%h exp=abcde000", mif.mem_alu_result); end
        drive(OPC_STORE, F3_LW, 7'h0, 5'd15, 5'd9, 5'd0, 32'h10, 32'h0, 32'h0, 32'hCAFE);
        step();
        total++; if (mif.mem_alu_result !== 32'hABCDE010 || mif.mem_store_data !== 32'hCAFE || mif.mem_is_store !== 1'b1 || mif.mem_reg_write !== 1'b0) begin bad++; $display("FAIL store got=%h/%h/%b/%b exp=abcde010/cafe/1/0", mif.mem_alu_result, mif.mem_store_data, mif.mem_is_store, mif.mem_reg_write); end
    endtask

    task automatic test_unsupported();
        drive(7'b0001111, 3'b000, 7'h0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (stall !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL fence_ctrl got=%b/%b exp=0/0", stall, flush); end
        step();
        total++; if (mif.mem_valid !== 1'b0 || mif.mem_rd_addr !== 5'd0) begin bad++; $display("FAIL fence_bubble got=%b/%0d exp=0/0", mif.mem_valid, mif.mem_rd_addr); end
        drive(OPC_JAL, 3'b000, 7'h0, 5'd0, 5'd0, 5'd1, 32'h40, 32'h0, 32'h0, 32'h0);
        ex_valid = 1'b0; #1;
        total++; if (flush !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL invalid_jal got=%b/%h exp=0/0", flush, redirect_pc); end
        step();
        total++; if (mif.mem_valid !== 1'b0) begin bad++; $display("FAIL invalid_bubble got=%b exp=0", mif.mem_valid); end
    endtask

    task automatic test_reset_mid_stall();
        drive(OPC_LOAD, F3_LW, 7'h0, 5'd0, 5'd0, 5'd3, 32'h100, 32'h8, 32'h0, 32'h0);
        step();
        drive(OPC_OP, F3_ADD, 7'h0, 5'd3, 5'd0, 5'd4, 32'h0, 32'hC, 32'h0, 32'h0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL pre_rst_stall got=%b exp=1", stall); end
        #1 rst_ = 1'b0; #1;
        total++; if (mif.mem_valid !== 1'b0 || mif.mem_is_load !== 1'b0 || mif.mem_alu_result !== 32'h0 || mif.mem_rd_addr !== 5'd0) begin bad++; $display("FAIL async_rst got=%b/%b/%h/%0d exp=0/0/0/0", mif.mem_valid, mif.mem_is_load, mif.mem_alu_result, mif.mem_rd_addr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        @(negedge clk); rst_ = 1'b1;
        drive(OPC_OP_IMM, F3_ADD, 7'h0, 5'd0, 5'd0, 5'd1, 32'd7, 32'h0, 32'h0, 32'h0);
        step();
        total++; if (mif.mem_valid !== 1'b1 || mif.mem_alu_result !== 32'd7) begin bad++; $display("FAIL post_rst got=%b/%h exp=1/7", mif.mem_valid, mif.mem_alu_result); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_forward();
        test_load_use();
        test_branch();
        test_jalr();
        test_alu();
        test_unsupported();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
